// File: rtl/sc_player_regshifter.sv
// Player row register with lives and collision FSM.
// The player pattern is loaded, shifted left or right with edge clamping,
// and compared against the obstacle row. A hit costs one life. The FSM
// stays in HIT until the next load, or stays in GAMEOVER until reset.
// Every output comes from a flop or is decoded from the registered state.
module sc_player_regshifter #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int LIVES_INIT    = 3
) (
  input  logic                     SC_PLAYER_STATEMACHINE_CLOCK_50,
  input  logic                     SC_PLAYER_STATEMACHINE_RESET_InHigh,
  input  logic [1:0]               SC_PLAYER_REGSHIFTER_ShiftSelection_In,
  input  logic                     SC_PLAYER_REGSHIFTER_LoadData_InLow,
  input  logic [DATAWIDTH_BUS-1:0] SC_PLAYER_REGSHIFTER_Data_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_PLAYER_REGSHIFTER_ObstacleRow_In,
  input  logic                     SC_PLAYER_REGSHIFTER_ObstacleValid_In,
  output logic [DATAWIDTH_BUS-1:0] SC_PLAYER_REGSHIFTER_Data_Out,
  output logic                     SC_PLAYER_REGSHIFTER_Lost_OutLow,
  output logic [1:0]               SC_PLAYER_REGSHIFTER_Lives_Out,
  output logic                     SC_PLAYER_REGSHIFTER_GameOver_OutLow,
  // Debug view of the registered FSM state (ALIVE=00, HIT=01, GAMEOVER=10)
  output logic [1:0]               SC_PLAYER_REGSHIFTER_State_Out
);

  // FSM encoding
  localparam logic [1:0] STATE_ALIVE    = 2'b00;
  localparam logic [1:0] STATE_HIT      = 2'b01;
  localparam logic [1:0] STATE_GAMEOVER = 2'b10;

  // Shift selector encoding; 00 and 11 both mean hold
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Reset values: the player starts on bit 1
  localparam logic [DATAWIDTH_BUS-1:0] DATA_RESET  = DATAWIDTH_BUS'(2);
  localparam logic [1:0]               LIVES_RESET = 2'(LIVES_INIT);

  // Handshake: ObstacleValid_In is a valid-only qualifier. There is no ready.
  // The obstacle row is looked at only in a cycle where valid is 1. A row that
  // is not examined, because of a load, HIT or GAMEOVER, is dropped and is not
  // held for a later cycle.

  logic [1:0]               state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] data_q,  data_d;
  logic [1:0]               lives_q, lives_d;

  logic                     load_req;
  logic                     overlap;
  logic                     collision;
  logic [DATAWIDTH_BUS-1:0] shifted;
  logic [1:0]               lives_dec;

  // Decode load and collision. Collision uses the pre-shift register value.
  always_comb begin
    load_req  = ~SC_PLAYER_REGSHIFTER_LoadData_InLow;
    overlap   = |(data_q & SC_PLAYER_REGSHIFTER_ObstacleRow_In);
    collision = (state_q == STATE_ALIVE) &&
                SC_PLAYER_REGSHIFTER_ObstacleValid_In &&
                !load_req && overlap;
  end

  // Candidate shift result. A shift that would push the set bit off the edge is clamped to hold.
  always_comb begin
    shifted = data_q;
    case (SC_PLAYER_REGSHIFTER_ShiftSelection_In)
      SHIFT_LEFT: begin
        if (!data_q[DATAWIDTH_BUS-1]) begin
          shifted = data_q << 1;
        end
      end
      SHIFT_RIGHT: begin
        if (!data_q[0]) begin
          shifted = data_q >> 1;
        end
      end
      default: shifted = data_q;
    endcase
  end

  // Lives counter: decrement on collision, saturating at zero
  always_comb begin
    lives_dec = (lives_q == 2'd0) ? 2'd0 : (lives_q - 2'd1);
    lives_d   = collision ? lives_dec : lives_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_ALIVE: begin
        if (collision) begin
          state_d = (lives_dec == 2'd0) ? STATE_GAMEOVER : STATE_HIT;
        end
      end
      STATE_HIT: begin
        if (load_req) begin
          state_d = STATE_ALIVE;
        end
      end
      STATE_GAMEOVER: begin
        state_d = STATE_GAMEOVER;
      end
      default: begin
        state_d = STATE_ALIVE;
      end
    endcase
  end

  // Player register: a load always wins; a shift applies only in ALIVE with no collision
  always_comb begin
    data_d = data_q;
    if (load_req) begin
      data_d = SC_PLAYER_REGSHIFTER_Data_In;
    end else if ((state_q == STATE_ALIVE) && !collision) begin
      data_d = shifted;
    end
  end

  // State flops with asynchronous active-high reset
  always_ff @(posedge SC_PLAYER_STATEMACHINE_CLOCK_50 or
              posedge SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
    if (SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
      state_q <= STATE_ALIVE;
      data_q  <= DATA_RESET;
      lives_q <= LIVES_RESET;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lives_q <= lives_d;
    end
  end

  assign SC_PLAYER_REGSHIFTER_Data_Out        = data_q;
  assign SC_PLAYER_REGSHIFTER_Lives_Out       = lives_q;
  assign SC_PLAYER_REGSHIFTER_Lost_OutLow     = (state_q == STATE_ALIVE);
  assign SC_PLAYER_REGSHIFTER_GameOver_OutLow = (state_q != STATE_GAMEOVER);
  assign SC_PLAYER_REGSHIFTER_State_Out       = state_q;

endmodule
